// File: rtl/csa_pipe_if.sv
// ============================================================================
// csa_pipe_if: operand/result stream bundle for csa_pipe (CSA_PIPE_OVF_EN adds ovf)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface csa_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CSA_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CSA_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

`default_nettype wire

// File: rtl/csa_pipe.sv
// ============================================================================
// csa_pipe: pipelined carry-select adder, one BLK-bit block per stage with a
//           valid/ready handshake. Macro CSA_PIPE_OVF_EN adds a signed ovf output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  csa_pipe_if.slave   bus
);

  localparam int NS = (BLK > 0) ? (WIDTH / BLK) : 1;

  if ((BLK < 1) || ((WIDTH % ((BLK > 0) ? BLK : 1)) != 0)) begin : g_bad_cfg
    $fatal(1, "csa_pipe: WIDTH (%0d) must be a positive multiple of BLK (%0d)", WIDTH, BLK);
  end

  logic advance;

  // The whole pipe freezes as one unit, so only the output stage gates the stall.
  assign advance      = !g_stage[NS-1].valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam int IN_W   = WIDTH - k*BLK;
    localparam int DONE_W = (k+1)*BLK;

    logic [IN_W-1:0]   op_a;
    logic [IN_W-1:0]   op_b;
    logic              carry_in;
    logic              valid_in;
    logic [BLK:0]      blk_sum;
    logic [DONE_W-1:0] sum_d;
    logic [DONE_W-1:0] sum_q;
    logic              valid_q;
    logic              carry_q;

    if (k == 0) begin : g_head
      assign op_a     = bus.a;
      assign op_b     = bus.b;
      assign carry_in = bus.cin;
      assign valid_in = bus.in_valid;
      assign blk_sum  = {1'b0, op_a[BLK-1:0]} + {1'b0, op_b[BLK-1:0]}
                      + {{BLK{1'b0}}, carry_in};
      assign sum_d    = blk_sum[BLK-1:0];
    end else begin : g_body
      logic [BLK:0] sum_c0;
      logic [BLK:0] sum_c1;

      assign op_a     = g_stage[k-1].g_skew.a_q;
      assign op_b     = g_stage[k-1].g_skew.b_q;
      assign carry_in = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      // Both carry hypotheses are formed up front; the registered carry only picks one.
      assign sum_c0   = {1'b0, op_a[BLK-1:0]} + {1'b0, op_b[BLK-1:0]};
      assign sum_c1   = {1'b0, op_a[BLK-1:0]} + {1'b0, op_b[BLK-1:0]}
                      + {{BLK{1'b0}}, 1'b1};
      assign blk_sum  = carry_in ? sum_c1 : sum_c0;
      assign sum_d    = {blk_sum[BLK-1:0], g_stage[k-1].sum_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_in;
        carry_q <= blk_sum[BLK];
        sum_q   <= sum_d;
      end
    end

    if (k < NS-1) begin : g_skew
      logic [IN_W-BLK-1:0] a_q;
      logic [IN_W-BLK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= op_a[IN_W-1:BLK];
          b_q <= op_b[IN_W-1:BLK];
        end
      end
    end

`ifdef CSA_PIPE_OVF_EN
    if (k == NS-1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      // The last block carries the operand sign bits, so overflow resolves here.
      assign ovf_d = (op_a[IN_W-1] == op_b[IN_W-1]) && (blk_sum[BLK-1] != op_a[IN_W-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign bus.out_valid = g_stage[NS-1].valid_q;
  assign bus.sum       = g_stage[NS-1].sum_q;
  assign bus.cout      = g_stage[NS-1].carry_q;
`ifdef CSA_PIPE_OVF_EN
  assign bus.ovf       = g_stage[NS-1].g_ovf.ovf_q;
`endif

endmodule

`default_nettype wire
